// File: rtl/collision_detector.sv
// Collision detector for one-pixel enemy moves: checks playfield bounds, two leading-edge
// tiles of the obstacle map (synchronous ROM), and overlap with Link's box.
module collision_detector #(
    parameter int MIN_X = 0,
    parameter int MAX_X = 304,
    parameter int MIN_Y = 0,
    parameter int MAX_Y = 224
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       check,
    input  logic [8:0] enemy_x_pos,
    input  logic [7:0] enemy_y_pos,
    input  logic [2:0] enemy_direction,
    input  logic [8:0] link_x_pos,
    input  logic [7:0] link_y_pos,
    output logic [8:0] map_addr,
    input  logic       map_data,
    output logic       collision,
    output logic       link_hit,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, CALC, RD_A, RD_B, RD_WAIT, RESULT
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE   = 3'd0,
        DIR_ATTACK = 3'd1,
        DIR_UP     = 3'd2,
        DIR_DOWN   = 3'd3,
        DIR_LEFT   = 3'd4,
        DIR_RIGHT  = 3'd5
    } dir_t;

    localparam logic [8:0] MIN_X_L = 9'(MIN_X);
    localparam logic [8:0] MAX_X_L = 9'(MAX_X);
    localparam logic [7:0] MIN_Y_L = 8'(MIN_Y);
    localparam logic [7:0] MAX_Y_L = 8'(MAX_Y);

    state_t     state;
    logic [8:0] x_r, lx_r;
    logic [7:0] y_r, ly_r;
    dir_t       dir_r;
    logic       tile_a;

    logic       is_move, blocked;
    logic [8:0] px, ax, bx;
    logic [7:0] py, ay, by;
    logic [8:0] addr_a, addr_b;
    logic signed [9:0] dx, dy;
    logic       hit;

    // Tile index = tile_y*20 + tile_x, built from shifts so no multiplier is needed.
    function automatic logic [8:0] tile_addr(input logic [8:0] cx, input logic [7:0] cy);
        logic [3:0] ty;
        ty = cy[7:4];
        return {1'b0, ty, 4'b0} + {3'b0, ty, 2'b0} + {4'b0, cx[8:4]};
    endfunction

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        is_move = 1'b0;
        blocked = 1'b0;
        px      = x_r;
        py      = y_r;
        ax      = px;
        ay      = py;
        bx      = px;
        by      = py;
        case (dir_r)
            DIR_UP: begin
                is_move = 1'b1;
                blocked = (y_r <= MIN_Y_L);
                if (!blocked) py = y_r - 8'd1;
                ax = px;          ay = py;
                bx = px + 9'd15;  by = py;
            end
            DIR_DOWN: begin
                is_move = 1'b1;
                blocked = (y_r >= MAX_Y_L);
                if (!blocked) py = y_r + 8'd1;
                ax = px;          ay = py + 8'd15;
                bx = px + 9'd15;  by = py + 8'd15;
            end
            DIR_LEFT: begin
                is_move = 1'b1;
                blocked = (x_r <= MIN_X_L);
                if (!blocked) px = x_r - 9'd1;
                ax = px;          ay = py;
                bx = px;          by = py + 8'd15;
            end
            DIR_RIGHT: begin
                is_move = 1'b1;
                blocked = (x_r >= MAX_X_L);
                if (!blocked) px = x_r + 9'd1;
                ax = px + 9'd15;  ay = py;
                bx = px + 9'd15;  by = py + 8'd15;
            end
            default: ;
        endcase
        addr_a = tile_addr(ax, ay);
        addr_b = tile_addr(bx, by);
        dx     = $signed({1'b0, px}) - $signed({1'b0, lx_r});
        dy     = $signed({2'b0, py}) - $signed({2'b0, ly_r});
        hit    = (dx > -10'sd16) && (dx < 10'sd16) && (dy > -10'sd16) && (dy < 10'sd16);
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_r       <= '0;
            y_r       <= '0;
            lx_r      <= '0;
            ly_r      <= '0;
            dir_r     <= DIR_NONE;
            tile_a    <= 1'b0;
            map_addr  <= '0;
            collision <= 1'b0;
            link_hit  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (check) begin
                        x_r   <= enemy_x_pos;
                        y_r   <= enemy_y_pos;
                        dir_r <= dir_t'(enemy_direction);
                        lx_r  <= link_x_pos;
                        ly_r  <= link_y_pos;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (is_move && !blocked) begin
                        map_addr <= addr_a;
                        state    <= RD_A;
                    end else begin
                        collision <= blocked;
                        link_hit  <= hit;
                        done      <= 1'b1;
                        state     <= RESULT;
                    end
                end
                RD_A: begin
                    map_addr <= addr_b;
                    state    <= RD_B;
                end
                RD_B: begin
                    tile_a <= map_data;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    collision <= tile_a | map_data;
                    link_hit  <= hit;
                    done      <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
